// File: rtl/qos_ingress_classifier.sv
// Ingress classifier for the four-FIFO QoS block: holds one word, routes it by class,
// stalls while the destination is blocked and drops it after a programmable limit.
module qos_ingress_classifier #(
  parameter int unsigned CLASS_MSB   = 7,
  parameter int unsigned STALL_LIMIT = 16,
  parameter bit          PAUSE_ON_AF = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  DATA_IN,
  input  logic        VALID_IN,
  output logic        READY_OUT,
  input  logic        ENABLE,
  input  logic [3:0]  FULL,
  input  logic [3:0]  ALMOST_FULL,
  input  logic        CLR_STATS,
  output logic [7:0]  DATA_OUT,
  output logic [3:0]  PUSH,
  output logic [31:0] DROP_CNT,
  output logic        DROP_ERR,
  output logic        BUSY
);

  localparam int unsigned CNT_W = (STALL_LIMIT == 0) ? 1 : $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'((STALL_LIMIT == 0) ? 0 : STALL_LIMIT - 1);
  localparam logic DROP_EN = (STALL_LIMIT != 0);

  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] LOADED  = 2'd1;
  localparam logic [1:0] STALLED = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [7:0]       hold_data;
  logic [1:0]       hold_dest;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] stall_cnt_nxt;
  logic [3:0][7:0]  drop_cnt;
  logic             drop_err;
  logic             load;

  logic blocked;
  logic fire;
  logic drop;
  logic accept;

  // Destination flags are sampled in the same cycle the word is presented
  assign blocked   = FULL[hold_dest] | (PAUSE_ON_AF & ALMOST_FULL[hold_dest]);
  assign fire      = (state != EMPTY) & ~blocked;
  assign drop      = (state == STALLED) & blocked & DROP_EN & (stall_cnt == LIMIT_M1);
  assign READY_OUT = RESET & ENABLE & ((state == EMPTY) | fire | drop);
  assign accept    = VALID_IN & READY_OUT;

  assign PUSH     = fire ? 4'(4'b0001 << hold_dest) : 4'b0000;
  assign DATA_OUT = hold_data;
  assign BUSY     = (state != EMPTY);
  assign DROP_CNT = drop_cnt;
  assign DROP_ERR = drop_err;

  // Next-state and hold-register load decision
  always_comb begin
    state_nxt     = state;
    stall_cnt_nxt = stall_cnt;
    load          = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = LOADED;
          load      = 1'b1;
        end
      end
      LOADED: begin
        if (blocked) begin
          state_nxt     = STALLED;
          stall_cnt_nxt = '0;
        end else if (accept) begin
          load = 1'b1;
        end else begin
          state_nxt = EMPTY;
        end
      end
      STALLED: begin
        if (fire || drop) begin
          stall_cnt_nxt = '0;
          if (accept) begin
            state_nxt = LOADED;
            load      = 1'b1;
          end else begin
            state_nxt = EMPTY;
          end
        end else if (DROP_EN) begin
          stall_cnt_nxt = stall_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt     = EMPTY;
        stall_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= EMPTY;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_cnt_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hold_data <= '0;
      hold_dest <= '0;
    end else if (load) begin
      hold_data <= DATA_IN;
      hold_dest <= DATA_IN[CLASS_MSB -: 2];
    end
  end

  // Per-class saturating drop counters; a clear beats a coincident drop
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      drop_cnt <= '0;
      drop_err <= 1'b0;
    end else if (CLR_STATS) begin
      drop_cnt <= '0;
      drop_err <= 1'b0;
    end else if (drop) begin
      drop_err <= 1'b1;
      if (drop_cnt[hold_dest] != 8'hFF) begin
        drop_cnt[hold_dest] <= drop_cnt[hold_dest] + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_qos_ingress_classifier.sv
// Bench for qos_ingress_classifier: directed scenarios plus a randomized run
// checked against a word-age reference model.
module tb_qos_ingress_classifier;
  localparam int unsigned LIMIT = 16;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  DATA_IN;
  logic        VALID_IN;
  logic        READY_OUT;
  logic        ENABLE;
  logic [3:0]  FULL;
  logic [3:0]  ALMOST_FULL;
  logic        CLR_STATS;
  logic [7:0]  DATA_OUT;
  logic [3:0]  PUSH;
  logic [31:0] DROP_CNT;
  logic        DROP_ERR;
  logic        BUSY;

  int n_cmp = 0;
  int n_err = 0;

  qos_ingress_classifier #(.CLASS_MSB(7), .STALL_LIMIT(LIMIT), .PAUSE_ON_AF(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .DATA_IN(DATA_IN), .VALID_IN(VALID_IN), .READY_OUT(READY_OUT),
    .ENABLE(ENABLE), .FULL(FULL), .ALMOST_FULL(ALMOST_FULL), .CLR_STATS(CLR_STATS),
    .DATA_OUT(DATA_OUT), .PUSH(PUSH), .DROP_CNT(DROP_CNT), .DROP_ERR(DROP_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    VALID_IN = 1'b0; DATA_IN = 8'h00; ENABLE = 1'b1;
    FULL = 4'h0; ALMOST_FULL = 4'h0; CLR_STATS = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    idle_inputs();
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    RESET = 1'b0; VALID_IN = 1'b1; DATA_IN = 8'hFF;
    @(negedge CLK); #2;
    n_cmp++; if (READY_OUT !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", READY_OUT); end
    n_cmp++; if (PUSH !== 4'h0) begin n_err++; $display("FAIL reset_push: got %b want 0000", PUSH); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    n_cmp++; if (DATA_OUT !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", DATA_OUT); end
    n_cmp++; if (DROP_CNT !== 32'h0) begin n_err++; $display("FAIL reset_dropcnt: got %h want 0", DROP_CNT); end
    n_cmp++; if (DROP_ERR !== 1'b0) begin n_err++; $display("FAIL reset_droperr: got %b want 0", DROP_ERR); end
    @(negedge CLK);
    VALID_IN = 1'b0; RESET = 1'b1;
  endtask

  task automatic test_stream();
    logic [7:0] w [4];
    logic [3:0] e_push;
    w[0] = 8'h05; w[1] = 8'h45; w[2] = 8'h85; w[3] = 8'hC5;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (i < 4) begin VALID_IN = 1'b1; DATA_IN = w[i]; end
      else VALID_IN = 1'b0;
      #2;
      if (i < 4) begin
        n_cmp++; if (READY_OUT !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d]: got %b want 1", i, READY_OUT); end
      end
      if (i > 0) begin
        e_push = 4'(1 << (i - 1));
        n_cmp++; if (PUSH !== e_push) begin n_err++; $display("FAIL stream_push[%0d]: got %b want %b", i, PUSH, e_push); end
        n_cmp++; if (DATA_OUT !== w[i-1]) begin n_err++; $display("FAIL stream_data[%0d]: got %h want %h", i, DATA_OUT, w[i-1]); end
      end
    end
    @(negedge CLK); #2;
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL stream_idle: got %b want 0", BUSY); end
  endtask

  task automatic test_full_hold();
    @(negedge CLK);
    FULL = 4'b0100; DATA_IN = 8'h9A; VALID_IN = 1'b1;
    #2;
    n_cmp++; if (READY_OUT !== 1'b1) begin n_err++; $display("FAIL hold_accept: got %b want 1", READY_OUT); end
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK); VALID_IN = 1'b0; #2;
      n_cmp++; if (PUSH !== 4'h0) begin n_err++; $display("FAIL hold_push[%0d]: got %b want 0000", k, PUSH); end
      n_cmp++; if (READY_OUT !== 1'b0) begin n_err++; $display("FAIL hold_ready[%0d]: got %b want 0", k, READY_OUT); end
      n_cmp++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL hold_busy[%0d]: got %b want 1", k, BUSY); end
    end
    @(negedge CLK); FULL = 4'h0; #2;
    n_cmp++; if (PUSH !== 4'b0100) begin n_err++; $display("FAIL hold_release_push: got %b want 0100", PUSH); end
    n_cmp++; if (DATA_OUT !== 8'h9A) begin n_err++; $display("FAIL hold_release_data: got %h want 9a", DATA_OUT); end
    n_cmp++; if (DROP_CNT !== 32'h0) begin n_err++; $display("FAIL hold_dropcnt: got %h want 0", DROP_CNT); end
    @(negedge CLK); #2;
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL hold_drained: got %b want 0", BUSY); end
  endtask

  task automatic test_drop();
    do_reset();
    @(negedge CLK);
    ALMOST_FULL = 4'b0010; DATA_IN = 8'h40; VALID_IN = 1'b1;
    #2;
    n_cmp++; if (READY_OUT !== 1'b1) begin n_err++; $display("FAIL drop_accept: got %b want 1", READY_OUT); end
    for (int k = 1; k <= 17; k++) begin
      @(negedge CLK); DATA_IN = 8'h01; VALID_IN = 1'b1; #2;
      n_cmp++; if (PUSH !== 4'h0) begin n_err++; $display("FAIL drop_push[%0d]: got %b want 0000", k, PUSH); end
      n_cmp++; if (READY_OUT !== (k == 17)) begin n_err++; $display("FAIL drop_ready[%0d]: got %b want %b", k, READY_OUT, (k == 17)); end
    end
    @(negedge CLK); VALID_IN = 1'b0; #2;
    n_cmp++; if (PUSH !== 4'b0001) begin n_err++; $display("FAIL drop_next_push: got %b want 0001", PUSH); end
    n_cmp++; if (DATA_OUT !== 8'h01) begin n_err++; $display("FAIL drop_next_data: got %h want 01", DATA_OUT); end
    n_cmp++; if (DROP_CNT !== 32'h0000_0100) begin n_err++; $display("FAIL drop_cnt: got %h want 00000100", DROP_CNT); end
    n_cmp++; if (DROP_ERR !== 1'b1) begin n_err++; $display("FAIL drop_err: got %b want 1", DROP_ERR); end
    @(negedge CLK); ALMOST_FULL = 4'h0;
  endtask

  task automatic test_saturation();
    int e;
    do_reset();
    for (int c = 1; c <= 4422; c++) begin
      @(negedge CLK);
      FULL = 4'b1000; VALID_IN = 1'b1; DATA_IN = 8'hC3;
      #2;
      if (c >= 2 && (c - 2) % 17 == 0) begin
        e = (c - 2) / 17;
        if (e > 255) e = 255;
        n_cmp++; if (DROP_CNT[31:24] !== 8'(e) || DROP_CNT[23:0] !== 24'h0) begin
          n_err++; $display("FAIL sat_cnt[c=%0d]: got %h want %h000000", c, DROP_CNT, 8'(e));
        end
      end
    end
    @(negedge CLK); VALID_IN = 1'b0; CLR_STATS = 1'b1; #2;
    n_cmp++; if (DROP_ERR !== 1'b1) begin n_err++; $display("FAIL sat_err: got %b want 1", DROP_ERR); end
    @(negedge CLK); CLR_STATS = 1'b0; FULL = 4'h0; #2;
    n_cmp++; if (DROP_CNT !== 32'h0) begin n_err++; $display("FAIL clr_cnt: got %h want 0", DROP_CNT); end
    n_cmp++; if (DROP_ERR !== 1'b0) begin n_err++; $display("FAIL clr_err: got %b want 0", DROP_ERR); end
    n_cmp++; if (PUSH !== 4'b1000) begin n_err++; $display("FAIL sat_drain: got %b want 1000", PUSH); end
    @(negedge CLK);
  endtask

  task automatic test_enable();
    @(negedge CLK);
    idle_inputs(); VALID_IN = 1'b1; DATA_IN = 8'h85; #2;
    n_cmp++; if (READY_OUT !== 1'b1) begin n_err++; $display("FAIL en_accept: got %b want 1", READY_OUT); end
    @(negedge CLK); ENABLE = 1'b0; DATA_IN = 8'h11; #2;
    n_cmp++; if (PUSH !== 4'b0100) begin n_err++; $display("FAIL en_push: got %b want 0100", PUSH); end
    n_cmp++; if (DATA_OUT !== 8'h85) begin n_err++; $display("FAIL en_data: got %h want 85", DATA_OUT); end
    n_cmp++; if (READY_OUT !== 1'b0) begin n_err++; $display("FAIL en_ready_low: got %b want 0", READY_OUT); end
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); #2;
      n_cmp++; if (READY_OUT !== 1'b0) begin n_err++; $display("FAIL en_gate_ready[%0d]: got %b want 0", k, READY_OUT); end
      n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL en_gate_busy[%0d]: got %b want 0", k, BUSY); end
    end
    @(negedge CLK); ENABLE = 1'b1; #2;
    n_cmp++; if (READY_OUT !== 1'b1) begin n_err++; $display("FAIL en_resume: got %b want 1", READY_OUT); end
    @(negedge CLK); VALID_IN = 1'b0; #2;
    n_cmp++; if (PUSH !== 4'b0001) begin n_err++; $display("FAIL en_resume_push: got %b want 0001", PUSH); end
    n_cmp++; if (DATA_OUT !== 8'h11) begin n_err++; $display("FAIL en_resume_data: got %h want 11", DATA_OUT); end
    @(negedge CLK);
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge CLK);
    FULL = 4'b0010; DATA_IN = 8'h55; VALID_IN = 1'b1;
    @(negedge CLK); VALID_IN = 1'b0;
    repeat (8) @(negedge CLK);
    #2;
    n_cmp++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL arst_pre_busy: got %b want 1", BUSY); end
    FULL = 4'h0; RESET = 1'b0;
    #1;
    n_cmp++; if (PUSH !== 4'h0) begin n_err++; $display("FAIL arst_push: got %b want 0000", PUSH); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b want 0", BUSY); end
    n_cmp++; if (READY_OUT !== 1'b0) begin n_err++; $display("FAIL arst_ready: got %b want 0", READY_OUT); end
    @(negedge CLK); RESET = 1'b1;
    repeat (20) @(negedge CLK);
    #2;
    n_cmp++; if (DROP_CNT !== 32'h0 || DROP_ERR !== 1'b0) begin n_err++; $display("FAIL arst_stats: got %h/%b want 0/0", DROP_CNT, DROP_ERR); end
    @(negedge CLK); VALID_IN = 1'b1; DATA_IN = 8'h42; #2;
    n_cmp++; if (READY_OUT !== 1'b1) begin n_err++; $display("FAIL arst_accept: got %b want 1", READY_OUT); end
    @(negedge CLK); VALID_IN = 1'b0; #2;
    n_cmp++; if (PUSH !== 4'b0010) begin n_err++; $display("FAIL arst_route: got %b want 0010", PUSH); end
    n_cmp++; if (DATA_OUT !== 8'h42) begin n_err++; $display("FAIL arst_data: got %h want 42", DATA_OUT); end
    @(negedge CLK);
  endtask

  // Reference: a held word is dropped on its (LIMIT+1)-th consecutive blocked cycle
  task automatic test_random();
    bit         m_held = 1'b0;
    logic [7:0] m_word = 8'h00;
    int         m_age = 0;
    int         m_cnt [4];
    bit         m_err = 1'b0;
    bit         pend = 1'b0;
    logic [1:0] dest;
    bit         blk, e_drop, e_ready, acc;
    logic [3:0] e_push;
    logic [31:0] e_cnt;
    for (int d = 0; d < 4; d++) m_cnt[d] = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      if ($urandom_range(0, 29) == 0) begin
        FULL = 4'($urandom) & 4'($urandom);
        ALMOST_FULL = 4'($urandom) & 4'($urandom);
      end
      ENABLE = ($urandom_range(0, 9) != 0);
      CLR_STATS = ($urandom_range(0, 149) == 0);
      if (!pend) begin
        VALID_IN = ($urandom_range(0, 2) != 0);
        DATA_IN = 8'($urandom);
      end
      #2;
      dest = m_word[7:6];
      blk = m_held && (FULL[dest] || ALMOST_FULL[dest]);
      e_push = (m_held && !blk) ? 4'(1 << dest) : 4'h0;
      e_drop = blk && (m_age == int'(LIMIT));
      e_ready = ENABLE && (!m_held || !blk || e_drop);
      e_cnt = {8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])};
      n_cmp++; if (READY_OUT !== e_ready) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, READY_OUT, e_ready); end
      n_cmp++; if (PUSH !== e_push) begin n_err++; $display("FAIL rnd_push[%0d]: got %b want %b", c, PUSH, e_push); end
      n_cmp++; if (BUSY !== m_held) begin n_err++; $display("FAIL rnd_busy[%0d]: got %b want %b", c, BUSY, m_held); end
      n_cmp++; if (DROP_CNT !== e_cnt) begin n_err++; $display("FAIL rnd_dropcnt[%0d]: got %h want %h", c, DROP_CNT, e_cnt); end
      n_cmp++; if (DROP_ERR !== m_err) begin n_err++; $display("FAIL rnd_droperr[%0d]: got %b want %b", c, DROP_ERR, m_err); end
      if (m_held) begin
        n_cmp++; if (DATA_OUT !== m_word) begin n_err++; $display("FAIL rnd_data[%0d]: got %h want %h", c, DATA_OUT, m_word); end
      end
      if (e_drop) begin
        if (m_cnt[dest] < 255) m_cnt[dest]++;
        m_err = 1'b1;
      end
      if (CLR_STATS) begin
        for (int d = 0; d < 4; d++) m_cnt[d] = 0;
        m_err = 1'b0;
      end
      acc = VALID_IN && e_ready;
      if (acc) begin m_held = 1'b1; m_word = DATA_IN; m_age = 0; end
      else if (m_held && (!blk || e_drop)) m_held = 1'b0;
      else if (m_held) m_age++;
      pend = VALID_IN && !e_ready;
    end
    @(negedge CLK); idle_inputs();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full_hold();
    test_drop();
    test_saturation();
    test_enable();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
